// File: rtl/irq_priority_encoder_if.sv
// Request/grant bundle between peripheral flag inputs and the interrupt encoder.
// The encoder side uses the slave modport; the request source uses master.
interface irq_priority_encoder_if #(
    parameter int unsigned N      = 8,
    parameter int unsigned CODE_W = $clog2(N)
);
    logic [N-1:0]      req;
    logic [N-1:0]      mask;
    logic              ack;
    logic [CODE_W-1:0] code;
    logic              valid;
    logic [N-1:0]      pending;
    logic              overrun;

    modport master (
        output req, mask, ack,
        input  code, valid, pending, overrun
    );

    modport slave (
        input  req, mask, ack,
        output code, valid, pending, overrun
    );
endinterface

// File: rtl/irq_priority_encoder.sv
// Sticky edge-triggered request collector with priority encoding and a
// valid/ack handshake towards the control sequencer.
module irq_priority_encoder #(
    parameter int unsigned N         = 8,
    parameter int unsigned CODE_W    = $clog2(N),
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    irq_priority_encoder_if.slave bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [N-1:0]      req_q;
    logic [N-1:0]      pending_q, pending_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    logic [N-1:0]      rise;
    logic [N-1:0]      clr;
    logic [N-1:0]      elig;
    logic [CODE_W-1:0] prio_idx;

    // Edge detect and sticky pending; a new edge beats a same-cycle clear.
    always_comb begin
        rise = bus.req & ~req_q;
        clr  = '0;
        if (valid_q && bus.ack) begin
            clr = N'(1) << code_q;
        end
        pending_d = (pending_q & ~clr) | rise;
        overrun_d = overrun_q | (|(rise & pending_q & ~clr));
        elig      = pending_q & bus.mask;
    end

    // The last match written wins, so scan towards the highest-priority end.
    always_comb begin
        prio_idx = '0;
        if (LSB_FIRST) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (elig[i]) prio_idx = CODE_W'(i);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (elig[i]) prio_idx = CODE_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (|elig) begin
                    code_d  = prio_idx;
                    valid_d = 1'b1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Presented code is frozen until the consumer accepts it.
                if (bus.ack) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= bus.req;
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.code    = code_q;
    assign bus.valid   = valid_q;
    assign bus.pending = pending_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Directed bench for irq_priority_encoder: a vector table for the LSB-first
// build plus hand sequences for level hold, mid-grant reset and MSB-first order.
module tb_irq_priority_encoder;

    logic clk;
    logic rst_a;
    logic rst_b;

    irq_priority_encoder_if #(.N(8)) bus_a ();
    irq_priority_encoder_if #(.N(8)) bus_b ();

    irq_priority_encoder #(.N(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    irq_priority_encoder #(.N(8), .LSB_FIRST(1'b0)) u_msb (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] mask;
        logic       ack;
        logic [2:0] code;
        logic       valid;
        logic [7:0] pending;
        logic       overrun;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void add(input logic rst, input logic [7:0] req,
                                input logic [7:0] mask, input logic ack,
                                input logic [2:0] code, input logic valid,
                                input logic [7:0] pend, input logic ovr);
        vec_t v;
        v.rst = rst; v.req = req; v.mask = mask; v.ack = ack;
        v.code = code; v.valid = valid; v.pending = pend; v.overrun = ovr;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic valid, input logic [2:0] code,
                         input logic [7:0] pend, input logic ovr, input logic chk_code);
        check({tag, ".valid"}, 32'(bus_a.valid), 32'(valid));
        check({tag, ".pending"}, 32'(bus_a.pending), 32'(pend));
        check({tag, ".overrun"}, 32'(bus_a.overrun), 32'(ovr));
        if (chk_code) check({tag, ".code"}, 32'(bus_a.code), 32'(code));
    endtask

    task automatic chk_b(input string tag, input logic valid, input logic [2:0] code,
                         input logic [7:0] pend, input logic chk_code);
        check({tag, ".valid"}, 32'(bus_b.valid), 32'(valid));
        check({tag, ".pending"}, 32'(bus_b.pending), 32'(pend));
        if (chk_code) check({tag, ".code"}, 32'(bus_b.code), 32'(code));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_p;

        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.req = 8'h00; bus_a.mask = 8'hFF; bus_a.ack = 1'b0;
        bus_b.req = 8'h00; bus_b.mask = 8'hFF; bus_b.ack = 1'b0;

        //   rst   req    mask   ack   code  valid pend   ovr
        add(1'b1, 8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0); // reset
        add(1'b1, 8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0);
        add(1'b0, 8'h10, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h10, 1'b0); // single request
        add(1'b0, 8'h10, 8'hFF, 1'b0, 3'd4, 1'b1, 8'h10, 1'b0);
        add(1'b0, 8'h10, 8'hFF, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
        add(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0);
        add(1'b0, 8'h0A, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h0A, 1'b0); // priority
        add(1'b0, 8'h0A, 8'hFF, 1'b0, 3'd1, 1'b1, 8'h0A, 1'b0);
        add(1'b0, 8'h0A, 8'hFF, 1'b1, 3'd0, 1'b0, 8'h08, 1'b0);
        add(1'b0, 8'h0A, 8'hFF, 1'b0, 3'd3, 1'b1, 8'h08, 1'b0);
        add(1'b0, 8'h0A, 8'hFF, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
        add(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0);
        add(1'b0, 8'h81, 8'h80, 1'b0, 3'd0, 1'b0, 8'h81, 1'b0); // mask and hold
        add(1'b0, 8'h81, 8'h80, 1'b0, 3'd7, 1'b1, 8'h81, 1'b0);
        add(1'b0, 8'h81, 8'h01, 1'b0, 3'd7, 1'b1, 8'h81, 1'b0);
        add(1'b0, 8'h81, 8'h01, 1'b0, 3'd7, 1'b1, 8'h81, 1'b0);
        add(1'b0, 8'h81, 8'h01, 1'b1, 3'd0, 1'b0, 8'h01, 1'b0);
        add(1'b0, 8'h81, 8'h01, 1'b0, 3'd0, 1'b1, 8'h01, 1'b0);
        add(1'b0, 8'h81, 8'h01, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
        add(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0);
        add(1'b0, 8'h04, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h04, 1'b0); // set beats clear
        add(1'b0, 8'h00, 8'hFF, 1'b0, 3'd2, 1'b1, 8'h04, 1'b0);
        add(1'b0, 8'h04, 8'hFF, 1'b1, 3'd0, 1'b0, 8'h04, 1'b0);
        add(1'b0, 8'h04, 8'hFF, 1'b0, 3'd2, 1'b1, 8'h04, 1'b0);
        add(1'b0, 8'h04, 8'hFF, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
        add(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0);
        add(1'b0, 8'h20, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h20, 1'b0); // overrun
        add(1'b0, 8'h00, 8'hFF, 1'b0, 3'd5, 1'b1, 8'h20, 1'b0);
        add(1'b0, 8'h20, 8'hFF, 1'b0, 3'd5, 1'b1, 8'h20, 1'b1);
        add(1'b0, 8'h00, 8'hFF, 1'b0, 3'd5, 1'b1, 8'h20, 1'b1);
        add(1'b0, 8'h00, 8'hFF, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1);
        add(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_a      = vecs[i].rst;
            bus_a.req  = vecs[i].req;
            bus_a.mask = vecs[i].mask;
            bus_a.ack  = vecs[i].ack;
            tick();
            chk_a($sformatf("row%0d", i), vecs[i].valid, vecs[i].code, vecs[i].pending,
                  vecs[i].overrun, vecs[i].valid | vecs[i].rst);
        end

        // Level hold: all lines high, each granted once in order, no re-arming.
        bus_a.ack = 1'b0; bus_a.req = 8'hFF; bus_a.mask = 8'hFF;
        tick();
        chk_a("hold.load", 1'b0, 3'd0, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bus_a.ack = 1'b0;
            tick();
            exp_p = 8'hFF << i;
            chk_a($sformatf("hold.grant%0d", i), 1'b1, 3'(i), exp_p, 1'b1, 1'b1);
            bus_a.ack = 1'b1;
            tick();
            exp_p = 8'hFF << (i + 1);
            chk_a($sformatf("hold.ack%0d", i), 1'b0, 3'd0, exp_p, 1'b1, 1'b0);
        end
        bus_a.ack = 1'b0;
        tick();
        tick();
        chk_a("hold.quiet", 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);

        // Reset while code 6 is presented; held level re-arms after reset.
        bus_a.req = 8'h00;
        tick();
        bus_a.req = 8'h40;
        tick();
        tick();
        chk_a("mid.grant", 1'b1, 3'd6, 8'h40, 1'b1, 1'b1);
        rst_a = 1'b1;
        tick();
        chk_a("mid.reset", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
        rst_a = 1'b0;
        tick();
        chk_a("mid.rearm", 1'b0, 3'd0, 8'h40, 1'b0, 1'b0);
        tick();
        chk_a("mid.regrant", 1'b1, 3'd6, 8'h40, 1'b0, 1'b1);
        bus_a.ack = 1'b1;
        tick();
        chk_a("mid.ack", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        bus_a.ack = 1'b0;
        tick();
        chk_a("mid.once", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);

        // MSB-first build: highest index wins.
        tick();
        chk_b("msb.reset", 1'b0, 3'd0, 8'h00, 1'b1);
        rst_b = 1'b0;
        bus_b.req = 8'h0A;
        tick();
        chk_b("msb.load", 1'b0, 3'd0, 8'h0A, 1'b0);
        tick();
        chk_b("msb.first", 1'b1, 3'd3, 8'h0A, 1'b1);
        bus_b.ack = 1'b1;
        tick();
        chk_b("msb.ack1", 1'b0, 3'd0, 8'h02, 1'b0);
        bus_b.ack = 1'b0;
        tick();
        chk_b("msb.second", 1'b1, 3'd1, 8'h02, 1'b1);
        bus_b.ack = 1'b1;
        tick();
        chk_b("msb.ack2", 1'b0, 3'd0, 8'h00, 1'b0);
        bus_b.ack = 1'b0;
        bus_b.req = 8'h81;
        tick();
        tick();
        chk_b("msb.top", 1'b1, 3'd7, 8'h81, 1'b1);
        bus_b.ack = 1'b1;
        tick();
        bus_b.ack = 1'b0;
        tick();
        chk_b("msb.bottom", 1'b1, 3'd0, 8'h01, 1'b1);
        check("msb.overrun", 32'(bus_b.overrun), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
